// File: rtl/pcm_pkg.sv
// rtl/pcm_pkg.sv - shared constants, FSM states and helpers for the PCM refill DMA
package pcm_pkg;

  localparam logic [1:0] REG_CONTROL = 2'd0;
  localparam logic [1:0] REG_ADDRESS = 2'd1;
  localparam logic [1:0] REG_LENGTH  = 2'd2;
  localparam logic [1:0] REG_REMAIN  = 2'd3;

  localparam int CTRL_START  = 0;
  localparam int CTRL_DONE   = 1;
  localparam int CTRL_LOOP   = 2;
  localparam int CTRL_IRQENA = 31;

  localparam int FIFO_REFILL_WORDS = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SPACE,
    ST_ISSUE,
    ST_DRAIN,
    ST_FINISH,
    ST_ABORT
  } pcm_state_t;

  function automatic logic [8:0] blk_size(input logic [23:0] remain, input logic [8:0] block);
    return (remain > {15'b0, block}) ? block : remain[8:0];
  endfunction

endpackage

// File: rtl/pcm_dma_feeder_if.sv
// rtl/pcm_dma_feeder_if.sv - register slave, read master and FIFO write port bundle
interface pcm_dma_feeder_if;

  logic [1:0]  avs_address;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        ins_irq;

  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  logic        coe_pcm_space;
  logic        coe_pcm_wrreq;
  logic [31:0] coe_pcm_wrdata;

  modport master (
    input  avs_address, avs_read, avs_write, avs_writedata,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid, coe_pcm_space,
    output avs_readdata, ins_irq, avm_address, avm_read, coe_pcm_wrreq, coe_pcm_wrdata
  );

  modport slave (
    output avs_address, avs_read, avs_write, avs_writedata,
    output avm_waitrequest, avm_readdata, avm_readdatavalid, coe_pcm_space,
    input  avs_readdata, ins_irq, avm_address, avm_read, coe_pcm_wrreq, coe_pcm_wrdata
  );

endinterface

// File: rtl/pcm_dma_pending.sv
// rtl/pcm_dma_pending.sv - outstanding read counter and next-cycle issue permit
module pcm_dma_pending
  import pcm_pkg::*;
#(
  parameter int MAX_PENDING = 8
) (
  input  logic csi_clk,
  input  logic csi_reset,
  input  logic accept,
  input  logic rdv,
  output logic ret_ok,
  output logic idle_next,
  output logic permit_next
);

  localparam logic [4:0] LIMIT = 5'(MAX_PENDING);

  logic [4:0] count;
  logic [4:0] count_next;

  // A return with nothing outstanding belongs to a burst cut off by reset.
  assign ret_ok = rdv && (count != 5'd0);

  always_comb begin
    count_next = count;
    if (accept && !ret_ok)
      count_next = count + 5'd1;
    else if (!accept && ret_ok)
      count_next = count - 5'd1;
  end

  assign idle_next   = (count_next == 5'd0);
  assign permit_next = (count_next < LIMIT);

  always_ff @(posedge csi_clk) begin
    if (csi_reset)
      count <= 5'd0;
    else
      count <= count_next;
  end

endmodule

// File: rtl/pcm_dma_feeder.sv
// rtl/pcm_dma_feeder.sv - memory-to-PCM FIFO refill DMA; LOOP mode under PCM_DMA_FEEDER_LOOP_EN
module pcm_dma_feeder
  import pcm_pkg::*;
#(
  parameter int BLOCK_WORDS = 64,
  parameter int MAX_PENDING = 8
) (
  input  logic             csi_clk,
  input  logic             csi_reset,
  pcm_dma_feeder_if.master bus
);

  localparam int         BLK_CLAMP = (BLOCK_WORDS > FIFO_REFILL_WORDS) ? FIFO_REFILL_WORDS : BLOCK_WORDS;
  localparam logic [8:0] BLK       = BLK_CLAMP[8:0];

  pcm_state_t  state;
  logic        guard;
  logic        irqena, loop_q, done;
  logic [29:0] addr_reg, waddr;
  logic [23:0] len_reg, remain;
  logic [8:0]  blk, blk_next;
  logic        rd_q, wrreq_q;
  logic [31:0] wrdata_q, rdata;

  logic busy, ctrl_wr, start_req, abort_req, done_set;
  logic accept, ret_ok, idle_next, permit_next;

  assign busy      = (state != ST_IDLE);
  assign ctrl_wr   = bus.avs_write && (bus.avs_address == REG_CONTROL);
  assign start_req = ctrl_wr && bus.avs_writedata[CTRL_START] && !busy;
  assign abort_req = ctrl_wr && !bus.avs_writedata[CTRL_START] && busy;
  assign accept    = rd_q && !bus.avm_waitrequest;
  assign blk_next  = blk - {8'b0, accept};
  assign done_set  = ((state == ST_FINISH) && !abort_req) || (start_req && (len_reg == 24'd0));

  pcm_dma_pending #(.MAX_PENDING(MAX_PENDING)) u_pending (
    .csi_clk     (csi_clk),
    .csi_reset   (csi_reset),
    .accept      (accept),
    .rdv         (bus.avm_readdatavalid),
    .ret_ok      (ret_ok),
    .idle_next   (idle_next),
    .permit_next (permit_next)
  );

  always_ff @(posedge csi_clk) begin
    if (csi_reset) begin
      state  <= ST_IDLE;
      guard  <= 1'b0;
      waddr  <= 30'd0;
      remain <= 24'd0;
      blk    <= 9'd0;
      rd_q   <= 1'b0;
    end else if (abort_req) begin
      state <= ST_ABORT;
      rd_q  <= 1'b0;
      if (accept) begin
        waddr  <= waddr + 30'd1;
        remain <= remain - 24'd1;
      end
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start_req && (len_reg != 24'd0)) begin
            waddr  <= addr_reg;
            remain <= len_reg;
            guard  <= 1'b1;
            state  <= ST_WAIT_SPACE;
          end
        end
        ST_WAIT_SPACE: begin
          // space is blind during the entry edge and the first cycle here
          guard <= 1'b0;
          if (!guard && bus.coe_pcm_space) begin
            blk   <= blk_size(remain, BLK);
            rd_q  <= permit_next;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (accept) begin
            waddr  <= waddr + 30'd1;
            remain <= remain - 24'd1;
          end
          blk <= blk_next;
          if (blk_next == 9'd0) begin
            rd_q  <= 1'b0;
            state <= ST_DRAIN;
          end else if (!(rd_q && bus.avm_waitrequest)) begin
            rd_q <= permit_next;
          end
        end
        ST_DRAIN: begin
          if (idle_next) begin
            if (remain != 24'd0) begin
              guard <= 1'b1;
              state <= ST_WAIT_SPACE;
            end else begin
              state <= ST_FINISH;
            end
          end
        end
        ST_FINISH: begin
`ifdef PCM_DMA_FEEDER_LOOP_EN
          if (loop_q) begin
            waddr  <= addr_reg;
            remain <= len_reg;
            guard  <= 1'b1;
            state  <= ST_WAIT_SPACE;
          end else begin
            state <= ST_IDLE;
          end
`else
          state <= ST_IDLE;
`endif
        end
        ST_ABORT: begin
          if (idle_next)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge csi_clk) begin
    if (csi_reset) begin
      irqena   <= 1'b0;
      done     <= 1'b0;
      addr_reg <= 30'd0;
      len_reg  <= 24'd0;
    end else begin
      if (ctrl_wr)
        irqena <= bus.avs_writedata[CTRL_IRQENA];
      if (bus.avs_write && !busy && (bus.avs_address == REG_ADDRESS))
        addr_reg <= bus.avs_writedata[31:2];
      if (bus.avs_write && !busy && (bus.avs_address == REG_LENGTH))
        len_reg <= bus.avs_writedata[23:0];
      if (done_set)
        done <= 1'b1;
      else if (ctrl_wr && bus.avs_writedata[CTRL_DONE])
        done <= 1'b0;
    end
  end

`ifdef PCM_DMA_FEEDER_LOOP_EN
  always_ff @(posedge csi_clk) begin
    if (csi_reset)
      loop_q <= 1'b0;
    else if (ctrl_wr)
      loop_q <= bus.avs_writedata[CTRL_LOOP];
  end
`else
  assign loop_q = 1'b0;
`endif

  always_ff @(posedge csi_clk) begin
    if (csi_reset) begin
      wrreq_q  <= 1'b0;
      wrdata_q <= 32'd0;
    end else begin
      wrreq_q <= ret_ok;
      if (ret_ok)
        wrdata_q <= bus.avm_readdata;
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (bus.avs_read) begin
      case (bus.avs_address)
        REG_CONTROL: rdata = {irqena, 28'd0, loop_q, done, busy};
        REG_ADDRESS: rdata = {addr_reg, 2'b00};
        REG_LENGTH:  rdata = {8'd0, len_reg};
        default:     rdata = {8'd0, remain};
      endcase
    end
  end

  assign bus.avs_readdata   = rdata;
  assign bus.ins_irq        = done && irqena;
  assign bus.avm_address    = {waddr, 2'b00};
  assign bus.avm_read       = rd_q;
  assign bus.coe_pcm_wrreq  = wrreq_q;
  assign bus.coe_pcm_wrdata = wrdata_q;

endmodule

// File: tb/tb_pcm_dma_feeder.sv
// tb/tb_pcm_dma_feeder.sv - directed bench for pcm_dma_feeder with a latency/waitrequest memory model
module tb_pcm_dma_feeder;
  import pcm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pcm_dma_feeder_if bus ();

  pcm_dma_feeder #(.BLOCK_WORDS(64), .MAX_PENDING(8)) dut (
    .csi_clk   (clk),
    .csi_reset (rst),
    .bus       (bus)
  );

  int errors = 0;
  int checks = 0;

  int lat = 1;
  bit wr_rand = 0;
  int stall_at = 1 << 30;
  int cyc = 0;
  int acc_cnt, wr_cnt, max_out, outstanding, stab_err, data_err, lat_err;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] exp_q[$];
  logic [31:0] acc_addr[$];
  bit prev_rdv, prev_read, prev_wait;
  logic [31:0] prev_addr;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Memory and FIFO model: drives the read-master inputs for the next rising edge.
  always @(negedge clk) begin
    bit ac, rv, wt;
    if (rst) begin
      pend_addr.delete();
      pend_due.delete();
      exp_q.delete();
      bus.avm_waitrequest   = 1'b0;
      bus.avm_readdatavalid = 1'b0;
      bus.avm_readdata      = 32'd0;
      prev_rdv = 0; prev_read = 0; prev_wait = 0; outstanding = 0;
    end else begin
      if (bus.coe_pcm_wrreq !== prev_rdv) lat_err++;
      if (bus.coe_pcm_wrreq === 1'b1) begin
        wr_cnt++;
        if (exp_q.size() == 0) data_err++;
        else begin
          if (bus.coe_pcm_wrdata !== exp_q[0]) data_err++;
          void'(exp_q.pop_front());
        end
      end
      if (prev_read && prev_wait && (bus.avm_read !== 1'b1 || bus.avm_address !== prev_addr)) stab_err++;
      wt = (acc_cnt >= stall_at) || (wr_rand && ($urandom_range(0, 3) == 0));
      rv = 0;
      if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
        rv = 1;
        bus.avm_readdata = mem_word(pend_addr[0]);
        exp_q.push_back(mem_word(pend_addr[0]));
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      bus.avm_waitrequest   = wt;
      bus.avm_readdatavalid = rv;
      ac = (bus.avm_read === 1'b1) && !wt;
      if (ac) begin
        pend_addr.push_back(bus.avm_address);
        pend_due.push_back(cyc + lat);
        acc_addr.push_back(bus.avm_address);
        acc_cnt++;
      end
      outstanding = outstanding + int'(ac) - int'(rv);
      if (outstanding > max_out) max_out = outstanding;
      prev_rdv  = rv;
      prev_read = (bus.avm_read === 1'b1);
      prev_wait = wt;
      prev_addr = bus.avm_address;
    end
    cyc++;
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reg_wr(logic [1:0] a, logic [31:0] d);
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    tick();
    bus.avs_write     = 1'b0;
  endtask

  task automatic reg_rd(logic [1:0] a, output logic [31:0] d);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    #1;
    d = bus.avs_readdata;
    bus.avs_read    = 1'b0;
  endtask

  task automatic wait_idle(string tag, int budget);
    logic [31:0] c;
    int n;
    n = 0;
    reg_rd(REG_CONTROL, c);
    while (c[CTRL_START] && n < budget) begin
      tick();
      n++;
      reg_rd(REG_CONTROL, c);
    end
    check(tag, {31'd0, c[CTRL_START]}, 32'd0);
  endtask

  task automatic wait_acc(string tag, int target, int budget);
    int n;
    n = 0;
    while (acc_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check(tag, {31'd0, acc_cnt >= target}, 32'd1);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    acc_cnt = 0; wr_cnt = 0; max_out = 0; stab_err = 0; data_err = 0; lat_err = 0;
    acc_addr.delete();
    stall_at = 1 << 30;
    wr_rand = 0;
    tick(3);
    rst = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c;
    bus.avs_address = 2'd0; bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_writedata = 32'd0;
    bus.coe_pcm_space = 1'b0;
    bus.avm_waitrequest = 1'b0; bus.avm_readdatavalid = 1'b0; bus.avm_readdata = 32'd0;

    // Reset state
    reset_dut();
    reg_rd(REG_CONTROL, c); check("rst_control", c, 32'd0);
    reg_rd(REG_ADDRESS, c); check("rst_address", c, 32'd0);
    reg_rd(REG_LENGTH, c);  check("rst_length", c, 32'd0);
    reg_rd(REG_REMAIN, c);  check("rst_remain", c, 32'd0);
    check("rst_flags", {29'd0, bus.avm_read, bus.coe_pcm_wrreq, bus.ins_irq}, 32'd0);
    check("rst_avm_address", bus.avm_address, 32'd0);
    check("rst_wrdata", bus.coe_pcm_wrdata, 32'd0);

    // Five words, single-cycle memory, IRQ enabled
    lat = 1;
    bus.coe_pcm_space = 1'b1;
    reg_wr(REG_ADDRESS, 32'h0000_1000);
    reg_wr(REG_LENGTH, 32'd5);
    reg_wr(REG_CONTROL, 32'h8000_0001);
    reg_rd(REG_CONTROL, c); check("t1_busy", {31'd0, c[CTRL_START]}, 32'd1);
    check("t1_read_n1", {31'd0, bus.avm_read}, 32'd0);
    tick();
    check("t1_read_n2", {31'd0, bus.avm_read}, 32'd0);
    tick();
    check("t1_read_n3", {31'd0, bus.avm_read}, 32'd1);
    wait_idle("t1_idle", 200);
    tick(2);
    check("t1_acc_cnt", acc_cnt, 32'd5);
    for (int i = 0; i < 5; i++) check($sformatf("t1_addr%0d", i), acc_addr[i], 32'h1000 + 32'(4 * i));
    check("t1_wr_cnt", wr_cnt, 32'd5);
    check("t1_data_err", data_err, 32'd0);
    check("t1_lat_err", lat_err, 32'd0);
    reg_rd(REG_CONTROL, c); check("t1_control", c, 32'h8000_0002);
    check("t1_irq", {31'd0, bus.ins_irq}, 32'd1);
    reg_rd(REG_REMAIN, c); check("t1_remain", c, 32'd0);
    reg_wr(REG_CONTROL, 32'h8000_0002);
    check("t1_irq_cleared", {31'd0, bus.ins_irq}, 32'd0);

    // 150 words in blocks of 64/64/22 with space withdrawn between blocks
    reset_dut();
    lat = 3;
    bus.coe_pcm_space = 1'b1;
    reg_wr(REG_ADDRESS, 32'h0000_2000);
    reg_wr(REG_LENGTH, 32'd150);
    reg_wr(REG_CONTROL, 32'h0000_0001);
    wait_acc("t2_reach64", 64, 500);
    bus.coe_pcm_space = 1'b0;
    tick(30);
    check("t2_block1", acc_cnt, 32'd64);
    bus.coe_pcm_space = 1'b1;
    wait_acc("t2_reach128", 128, 500);
    bus.coe_pcm_space = 1'b0;
    tick(30);
    check("t2_block2", acc_cnt, 32'd128);
    bus.coe_pcm_space = 1'b1;
    wait_idle("t2_idle", 500);
    tick(2);
    check("t2_acc_cnt", acc_cnt, 32'd150);
    check("t2_last_addr", acc_addr[149], 32'h0000_2254);
    check("t2_wr_cnt", wr_cnt, 32'd150);
    check("t2_data_err", data_err, 32'd0);
    reg_rd(REG_REMAIN, c); check("t2_remain", c, 32'd0);

    // Long latency, random waitrequest
    reset_dut();
    lat = 12;
    wr_rand = 1;
    bus.coe_pcm_space = 1'b1;
    reg_wr(REG_ADDRESS, 32'h0000_3000);
    reg_wr(REG_LENGTH, 32'd64);
    reg_wr(REG_CONTROL, 32'h0000_0001);
    wait_idle("t3_idle", 2000);
    tick(2);
    check("t3_max_out_le8", {31'd0, max_out <= 8}, 32'd1);
    check("t3_stable", stab_err, 32'd0);
    check("t3_wr_cnt", wr_cnt, 32'd64);
    check("t3_data_err", data_err, 32'd0);
    check("t3_lat_err", lat_err, 32'd0);

    // Abort after 10 accepted reads with returns in flight
    reset_dut();
    lat = 5;
    stall_at = 10;
    bus.coe_pcm_space = 1'b1;
    reg_wr(REG_ADDRESS, 32'h0000_4000);
    reg_wr(REG_LENGTH, 32'd40);
    reg_wr(REG_CONTROL, 32'h0000_0001);
    wait_acc("t4_reach10", 10, 200);
    tick();
    check("t4_in_flight", {31'd0, outstanding > 0}, 32'd1);
    reg_wr(REG_CONTROL, 32'h0000_0000);
    stall_at = 1 << 30;
    wait_idle("t4_idle", 200);
    tick(10);
    check("t4_acc_cnt", acc_cnt, 32'd10);
    check("t4_wr_cnt", wr_cnt, 32'd10);
    check("t4_data_err", data_err, 32'd0);
    reg_rd(REG_CONTROL, c); check("t4_control", c, 32'd0);
    reg_rd(REG_REMAIN, c);  check("t4_remain", c, 32'd30);

    // Zero length, register masking, writes ignored while busy
    reset_dut();
    lat = 1;
    bus.coe_pcm_space = 1'b1;
    reg_wr(REG_CONTROL, 32'h0000_0001);
    reg_rd(REG_CONTROL, c); check("t5_done_len0", c, 32'h0000_0002);
    tick(4);
    check("t5_no_read", acc_cnt, 32'd0);
    reg_wr(REG_ADDRESS, 32'h0000_1003);
    reg_rd(REG_ADDRESS, c); check("t5_addr_mask", c, 32'h0000_1000);
    reg_wr(REG_LENGTH, 32'hFF00_0005);
    reg_rd(REG_LENGTH, c);  check("t5_len_mask", c, 32'h0000_0005);
    bus.coe_pcm_space = 1'b0;
    reg_wr(REG_CONTROL, 32'h0000_0001);
    reg_wr(REG_ADDRESS, 32'h0000_5000);
    reg_wr(REG_LENGTH, 32'd9);
    reg_rd(REG_ADDRESS, c); check("t5_addr_busy", c, 32'h0000_1000);
    reg_rd(REG_LENGTH, c);  check("t5_len_busy", c, 32'h0000_0005);
    reg_rd(REG_REMAIN, c);  check("t5_remain_busy", c, 32'h0000_0005);
    reg_wr(REG_CONTROL, 32'h0000_0000);
    wait_idle("t5_idle", 50);
    reg_rd(REG_CONTROL, c); check("t5_done_kept", c, 32'h0000_0002);
    check("t5_no_read_abort", acc_cnt, 32'd0);

    // LOOP request with a 3-word buffer
    reset_dut();
    lat = 1;
    bus.coe_pcm_space = 1'b1;
    reg_wr(REG_ADDRESS, 32'h0000_1000);
    reg_wr(REG_LENGTH, 32'd3);
    reg_wr(REG_CONTROL, 32'h0000_0005);
`ifdef PCM_DMA_FEEDER_LOOP_EN
    wait_acc("t6_reach9", 9, 300);
    reg_rd(REG_CONTROL, c); check("t6_loop_control", c, 32'h0000_0007);
    for (int i = 0; i < 9; i++) check($sformatf("t6_addr%0d", i), acc_addr[i], 32'h1000 + 32'(4 * (i % 3)));
    reg_wr(REG_CONTROL, 32'h0000_0000);
    wait_idle("t6_idle", 200);
`else
    wait_idle("t6_idle", 200);
    tick(20);
    check("t6_acc_cnt", acc_cnt, 32'd3);
    for (int i = 0; i < 3; i++) check($sformatf("t6_addr%0d", i), acc_addr[i], 32'h1000 + 32'(4 * i));
    reg_rd(REG_CONTROL, c); check("t6_control", c, 32'h0000_0002);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
